// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler that sends one requester byte at a time on a shared idle-high
// serial line. Frame: start 0, 8 data bits LSB first, stop 1, then GAP idle-high cycles.
module serial_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int GAP  = 0,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] data,
   output logic [NREQ-1:0]   ack,
   output logic [IDW-1:0]    gnt_id,
   output logic              out,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [3:0]     GAP_LD   = 4'(GAP);
   localparam logic [IDW:0]   NREQ_EXT = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

   state_t         state_q, state_d;
   logic [7:0]     shreg_q, shreg_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [3:0]     gap_cnt_q, gap_cnt_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;

   logic [7:0]     req_byte [NREQ];
   logic [IDW:0]   rot_sum  [NREQ];
   logic [IDW-1:0] cand_idx [NREQ];
   logic [NREQ-1:0] cand_req;
   logic           win_valid;
   logic [IDW-1:0] win_idx;
   logic           arb_point;

   // cand_idx[k] is the requester k places after ptr, wrapped modulo NREQ
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_byte[gi] = data[8*gi +: 8];
         assign rot_sum[gi]  = {1'b0, ptr_q} + (IDW+1)'(gi);
         assign cand_idx[gi] = (rot_sum[gi] >= NREQ_EXT) ? IDW'(rot_sum[gi] - NREQ_EXT)
                                                         : IDW'(rot_sum[gi]);
         assign cand_req[gi] = req[cand_idx[gi]];
         assign ack[gi]      = (state_q == S_START) && (gnt_id_q == IDW'(gi));
      end
   endgenerate

   // Scan from the far end so the smallest offset from ptr is the final assignment
   always_comb begin
      win_valid = |req;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            win_idx = cand_idx[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         ptr_q     <= '0;
         gnt_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      ptr_d     = ptr_q;
      gnt_id_d  = gnt_id_q;
      arb_point = 1'b0;

      case (state_q)
         S_IDLE: begin
            arb_point = 1'b1;
         end
         S_START: begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
         end
         S_DATA: begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (GAP == 0) begin
               arb_point = 1'b1;
            end else begin
               state_d   = S_GAP;
               gap_cnt_d = GAP_LD;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 4'd1;
            if (gap_cnt_q == 4'd1) begin
               arb_point = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Granting from STOP or the last gap cycle makes frames abut with no idle cycle
      if (arb_point) begin
         if (win_valid) begin
            state_d  = S_START;
            shreg_d  = req_byte[win_idx];
            gnt_id_d = win_idx;
            ptr_d    = (win_idx == LAST_ID) ? '0 : win_idx + IDW'(1);
         end else begin
            state_d  = S_IDLE;
         end
      end
   end

   always_comb begin
      out  = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_START: begin
            out  = 1'b0;
            busy = 1'b1;
         end
         S_DATA: begin
            out  = shreg_q[0];
            busy = 1'b1;
         end
         S_STOP: begin
            busy = 1'b1;
            done = 1'b1;
         end
         S_GAP: begin
            busy = 1'b1;
         end
         default: begin
            out  = 1'b1;
         end
      endcase
   end

   assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: a frame-level model predicts each grant,
// and a line monitor decodes frames and compares them against the predictions.
module tb_serial_tx_arbiter;

   localparam int NR = 4;

   typedef struct {
      int         id;
      logic [7:0] b;
      int         start;
   } frame_t;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          sel    = 1'b0;
   int            gap_m  = 0;
   logic [NR-1:0] req_v  = '0;
   logic [8*NR-1:0] data_v = '0;

   logic [NR-1:0] req0, req1, ack0, ack1, ack_m;
   logic [1:0]    gnt0, gnt1, gnt_m;
   logic          out0, out1, out_m, busy0, busy1, busy_m, done0, done1, done_m;

   always #5 clk = ~clk;

   assign req0   = sel ? '0 : req_v;
   assign req1   = sel ? req_v : '0;
   assign ack_m  = sel ? ack1  : ack0;
   assign gnt_m  = sel ? gnt1  : gnt0;
   assign out_m  = sel ? out1  : out0;
   assign busy_m = sel ? busy1 : busy0;
   assign done_m = sel ? done1 : done0;

   serial_tx_arbiter #(.NREQ(NR), .GAP(0)) dut0 (
      .clk(clk), .reset(rst), .req(req0), .data(data_v), .ack(ack0),
      .gnt_id(gnt0), .out(out0), .busy(busy0), .done(done0)
   );

   serial_tx_arbiter #(.NREQ(NR), .GAP(3)) dut1 (
      .clk(clk), .reset(rst), .req(req1), .data(data_v), .ack(ack1),
      .gnt_id(gnt1), .out(out1), .busy(busy1), .done(done1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model: cycles left in the current frame+gap (0 = idle), round-robin pointer
   int     m_left = 0;
   int     m_ptr  = 0;
   frame_t exp_q[$];

   // requesters: small byte FIFOs per requester
   logic [7:0] pbuf [NR][16];
   int         prd  [NR];
   int         pwr  [NR];

   // monitor state and observations
   int         mi = 0;
   logic [7:0] mbits = '0;
   logic [7:0] last_byte = '0;
   frame_t     cur;
   int         seen_ids[$];
   int         seen_start[$];
   int         exp_ids[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic refresh(input int i);
      if (prd[i] != pwr[i]) begin
         req_v[i]         = 1'b1;
         data_v[i*8 +: 8] = pbuf[i][prd[i] % 16];
      end else begin
         req_v[i] = 1'b0;
      end
   endtask

   task automatic add_byte(input int i, input logic [7:0] b);
      pbuf[i][pwr[i] % 16] = b;
      pwr[i]++;
      refresh(i);
   endtask

   task automatic model_clear();
      m_left = 0;
      m_ptr  = 0;
      exp_q.delete();
      for (int i = 0; i < NR; i++) begin
         prd[i] = 0;
         pwr[i] = 0;
      end
      req_v = '0;
   endtask

   // One clock: predict what the coming edge does, then let requesters react to ack
   task automatic step();
      int     nl;
      int     w;
      frame_t f;
      nl = (m_left > 0) ? m_left - 1 : 0;
      if (!rst && m_left <= 1 && req_v != '0) begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            if (w < 0 && req_v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
         end
         f.id    = w;
         f.b     = data_v[w*8 +: 8];
         f.start = cyc + 1;
         exp_q.push_back(f);
         m_ptr = (w + 1) % NR;
         nl    = 10 + gap_m;
      end
      @(posedge clk);
      #1;
      m_left = nl;
      for (int i = 0; i < NR; i++) begin
         if (ack_m[i] && prd[i] != pwr[i]) begin
            prd[i]++;
            refresh(i);
         end
      end
   endtask

   task automatic run_idle(input string nm, input int maxc);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(m_left == 0 && req_v == '0 && mi == 0) && n < maxc);
      check({nm, "_bound"}, 32'(n < maxc), 32'd1);
      check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({nm, "_idle_out"}, 32'(out_m), 32'd1);
      check({nm, "_idle_busy"}, 32'(busy_m), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic clear_seen();
      seen_ids.delete();
      seen_start.delete();
      exp_ids.delete();
   endtask

   task automatic check_order(input string nm);
      check({nm, "_count"}, 32'(seen_ids.size()), 32'(exp_ids.size()));
      for (int k = 0; k < exp_ids.size() && k < seen_ids.size(); k++) begin
         check({nm, "_id"}, 32'(seen_ids[k]), 32'(exp_ids[k]));
      end
   endtask

   task automatic check_period(input string nm, input int period);
      for (int k = 1; k < seen_start.size(); k++) begin
         check({nm, "_period"}, 32'(seen_start[k] - seen_start[k-1]), 32'(period));
      end
   endtask

   task automatic random_run(input string nm, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            int i;
            i = int'($urandom_range(0, NR - 1));
            if (pwr[i] - prd[i] < 14) add_byte(i, 8'($urandom));
         end
         step();
      end
      run_idle(nm, 3000);
   endtask

   // Line monitor: decodes each frame and scores it against the model's prediction
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mi = 0;
         end else begin
            check("busy", 32'(busy_m), 32'(m_left != 0));
            check("done", 32'(done_m), 32'(m_left != 0 && m_left == gap_m + 1));
            if (mi == 0) begin
               if (out_m == 1'b0) begin
                  seen_ids.push_back(int'(gnt_m));
                  seen_start.push_back(cyc);
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_frame: got start bit, expected idle line (cycle %0d)", cyc);
                     cur.id = -1;
                     cur.b = 8'h00;
                     cur.start = 0;
                  end else begin
                     cur = exp_q.pop_front();
                     check("start_cycle", 32'(cyc), 32'(cur.start));
                     check("gnt_id", 32'(gnt_m), 32'(cur.id));
                     check("ack_start", 32'(ack_m), 32'(1 << cur.id));
                  end
                  mi = 1;
               end else begin
                  check("ack_idle", 32'(ack_m), 32'd0);
               end
            end else if (mi <= 8) begin
               mbits[mi-1] = out_m;
               check("ack_data", 32'(ack_m), 32'd0);
               mi++;
            end else begin
               check("stop_bit", 32'(out_m), 32'd1);
               last_byte = mbits;
               if (cur.id >= 0) check("frame_byte", 32'(mbits), 32'(cur.b));
               mi = 0;
            end
         end
      end
   end

   initial begin
      model_clear();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("rst_out", 32'(out_m), 32'd1);
      check("rst_busy", 32'(busy_m), 32'd0);
      check("rst_done", 32'(done_m), 32'd0);
      check("rst_ack", 32'(ack_m), 32'd0);
      check("rst_gnt", 32'(gnt_m), 32'd0);
      rst = 1'b0;

      // single byte A5 from requester 0
      clear_seen();
      add_byte(0, 8'hA5);
      run_idle("t1", 40);
      check("t1_byte", 32'(last_byte), 32'hA5);
      exp_ids.push_back(0);
      check_order("t1");

      // all requesters pending, back-to-back frames
      do_reset();
      clear_seen();
      add_byte(0, 8'h11); add_byte(1, 8'h22); add_byte(2, 8'h33); add_byte(3, 8'h44);
      add_byte(0, 8'h55);
      run_idle("t2", 100);
      exp_ids.push_back(0); exp_ids.push_back(1); exp_ids.push_back(2);
      exp_ids.push_back(3); exp_ids.push_back(0);
      check_order("t2");
      check_period("t2", 10);

      // pointer at 2 with requester 2 idle: 3, 0, 1 follow
      do_reset();
      clear_seen();
      add_byte(1, 8'h77);
      step();
      step();
      add_byte(3, 8'h3C); add_byte(0, 8'h5A); add_byte(1, 8'hC3);
      run_idle("t3", 100);
      exp_ids.push_back(1); exp_ids.push_back(3); exp_ids.push_back(0); exp_ids.push_back(1);
      check_order("t3");

      // data changes mid-frame do not affect the frame
      clear_seen();
      add_byte(1, 8'h0F);
      repeat (3) step();
      data_v[15:8] = 8'hF0;
      run_idle("t4", 40);
      check("t4_byte", 32'(last_byte), 32'h0F);

      // asynchronous reset during DATA
      clear_seen();
      add_byte(2, 8'h80);
      repeat (4) step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_out", 32'(out_m), 32'd1);
      check("arst_busy", 32'(busy_m), 32'd0);
      check("arst_ack", 32'(ack_m), 32'd0);
      model_clear();
      clear_seen();
      add_byte(2, 8'h21);
      add_byte(3, 8'h31);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_idle("t6", 60);
      exp_ids.push_back(2); exp_ids.push_back(3);
      check_order("t6");

      random_run("rand_a", 400);

      // GAP=3 instance
      rst = 1'b1;
      sel = 1'b1;
      gap_m = 3;
      do_reset();
      clear_seen();
      add_byte(1, 8'hFF); add_byte(1, 8'hFF); add_byte(1, 8'hFF);
      run_idle("tg", 100);
      exp_ids.push_back(1); exp_ids.push_back(1); exp_ids.push_back(1);
      check_order("tg");
      check_period("tg", 13);

      random_run("rand_b", 400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one serial output line among NREQ byte requesters.
- Each granted byte goes out in the codebase's serial frame format: start bit 0, 8 data bits LSB first, stop bit 1; the line idles at 1.
- Requesters are served round-robin; a frame is never interrupted.
- Sits upstream of the serial-data receiver FSM as the transmit-side scheduler for the shared link.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- GAP, 0: extra idle-high cycles inserted after each stop bit; legal range 0..15.
- IDW, $clog2(NREQ): width of gnt_id; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  request level; bit i high means requester i has a byte pending.
- data  input  8*NREQ  requester i byte on bits [8i+7:8i]; must be stable while req[i]=1 and ack[i]=0.
- ack  output  NREQ  one-cycle, one-hot pulse: byte of requester i captured.
- gnt_id  output  IDW  index of the requester whose frame is in flight.
- out  output  1  serial line.
- busy  output  1  high whenever a frame or gap is in progress.
- done  output  1  high for exactly the stop-bit cycle of each frame.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values: state=IDLE, out=1, ack=0, busy=0, done=0, gnt_id=0, round-robin pointer ptr=0.
- Reset mid-frame: the frame is aborted immediately and out returns to 1 without waiting for a clock. After release, the first winner is searched from index 0.
- States: IDLE, START, DATA, STOP, GAP. DATA uses a 3-bit bit counter, 0..7.
- Outputs per state: out=1 in IDLE, STOP and GAP; out=0 in START; out=shreg[0] in DATA. busy=1 in START, DATA, STOP and GAP. done=1 in STOP only.
- out is driven only from registered state or the shift register. There is no combinational path from req or data to out.
- Arbitration points: IDLE; STOP when GAP=0; the last GAP cycle when GAP>0.
- Arbitration rule: at an arbitration point, if |req=1 the winner w is the first set req bit searched from ptr upward, wrapping modulo NREQ.
- On the edge that grants w:
  - next state = START
  - shreg <= data[8w+7:8w]
  - gnt_id <= w
  - ptr <= (w+1) mod NREQ
  - ack[w]=1 for the following cycle (the START cycle) only.
- No request at an arbitration point: go to IDLE; ptr is unchanged.
- Other transitions:
  - START -> DATA with counter=0.
  - DATA: shreg shifts right by one each cycle; counter increments; after counter=7, go to STOP.
  - STOP -> GAP when GAP>0, with the gap counter loaded to GAP. Otherwise STOP is an arbitration point.
  - GAP counts down; the cycle with count=1 is the arbitration point.
- Latency: a req seen in IDLE at edge k puts out=0 during the cycle after edge k.
- Frame timing: a frame is 10 cycles. Back-to-back frames repeat every 10+GAP cycles with no extra idle cycle.
- Requester handshake:
  - A requester drops req[i], or presents its next byte, on the edge after it sees ack[i].
  - req[i] still high at the next arbitration point is treated as a new request.
  - Changes to req or data during a frame have no effect on that frame.
- Fairness: with all req high, service order is 0,1,...,NREQ-1,0,... Any requester waits at most NREQ-1 frames.
- Simultaneous requests with ptr pointing at a requester whose req is low: the search skips it and the first set bit above it wins, with wrap-around.
- gnt_id holds its value in IDLE and GAP until the next grant.

Test Plan:
- Reset, then req=4'b0001 with data0=8'hA5 for one cycle before the grant edge. Required: ack[0] pulse in the START cycle; out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; done high on the 10th cycle; then out=1 and busy=0.
- req=4'b1111 held, GAP=0, data bytes 8'h11/22/33/44. Required: frames in order 0,1,2,3,0; gnt_id follows that order; frames are contiguous at a 10-cycle period; exactly one ack bit per frame.
- ptr=2 after serving requester 1, then req=4'b1011. Required: requester 3 wins next, then 0, then 1 (2 is skipped).
- GAP=3, req[1] held with data 8'hFF. Required: after each stop bit, out=1 for 3 cycles, busy=1 through the gap, next start bit on cycle 14; done is not asserted in the gap.
- data1 changed from 8'h0F to 8'hF0 during DATA of requester 1's frame. Required: the transmitted bits are still 8'h0F.
- reset asserted asynchronously mid-DATA. Required: out=1, busy=0, ack=0 immediately. After release with req=4'b1100: requester 2 wins first.
